// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: operation select values and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_UMULL = 3'b100,
    OP_SMULL = 3'b101,
    OP_UDIV  = 3'b110,
    OP_SDIV  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input alu_op_e op);
    return op inside {OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV};
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return op inside {OP_UDIV, OP_SDIV};
  endfunction

  function automatic logic is_signed_op(input alu_op_e op);
    return op inside {OP_SMULL, OP_SDIV};
  endfunction

endpackage

// File: rtl/alu_iter_step.sv
// One radix-2 iteration on the shared {hi,lo} register pair: shift-add multiply
// (shifting right) or restoring divide (shifting left), selected by i_div.
module alu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // Multiply: hi accumulates the multiplicand when the current multiplier bit is set.
  assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);

  // Divide: the shifted partial remainder is kept only if the trial subtract fits.
  assign w_rem_sh = {i_hi, i_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, i_opnd};
  assign w_fits   = ~w_diff[WIDTH];

  assign o_hi = i_div ? (w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0])
                      : w_sum[WIDTH:1];
  assign o_lo = i_div ? {i_lo[WIDTH-2:0], w_fits}
                      : {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle ADD/SUB/AND/OR, WIDTH-iteration multiply and divide
// on operand magnitudes with sign correction applied on the final iteration.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags
);
  import alu_pkg::*;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam int               MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           r_state, w_next_state;
  alu_op_e          r_op, w_in_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result1, r_result2;
  logic [3:0]       r_flags;

  logic             w_accept, w_last, w_is_div, w_is_signed, w_sign_a, w_sign_b;
  logic [WIDTH-1:0] w_b_mag, w_step_hi, w_step_lo;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_alu_r1;
  logic             w_alu_c, w_alu_v;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quot_fix, w_rem_fix, w_fin_r1, w_fin_r2;
  logic [3:0]       w_fin_flags;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[MSB]) ? -v : v;
  endfunction

  assign w_in_op     = alu_op_e'(ALUControl);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_is_div    = is_div(r_op);
  assign w_is_signed = is_signed_op(r_op);
  assign w_sign_a    = w_is_signed & r_a[MSB];
  assign w_sign_b    = w_is_signed & r_b[MSB];
  assign w_b_mag     = magnitude(r_b, w_is_signed);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_EXEC: if (w_last) w_next_state = S_DONE;
      default: begin
        w_accept = start;
        if (start) w_next_state = is_iter(w_in_op) ? S_EXEC : S_DONE;
        else       w_next_state = S_IDLE;
      end
    endcase
  end

  // Single-cycle operations, evaluated on the live inputs at acceptance.
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_alu_r1 = '0;
    w_alu_c  = 1'b0;
    w_alu_v  = 1'b0;
    case (w_in_op)
      OP_ADD: begin
        w_alu_r1 = w_add[WIDTH-1:0];
        w_alu_c  = w_add[WIDTH];
        w_alu_v  = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_r1 = w_sub[WIDTH-1:0];
        w_alu_c  = ~w_sub[WIDTH];
        w_alu_v  = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
      end
      OP_AND:  w_alu_r1 = a & b;
      OP_OR:   w_alu_r1 = a | b;
      default: ;
    endcase
  end

  alu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (w_is_div),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .i_opnd (w_b_mag),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  // Sign correction applied to the outcome of the last iteration.
  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = (w_sign_a ^ w_sign_b) ? -w_prod : w_prod;
  assign w_quot_fix = (w_sign_a ^ w_sign_b) ? -w_step_lo : w_step_lo;
  assign w_rem_fix  = w_sign_a ? -w_step_hi : w_step_hi;

  always_comb begin
    w_fin_r1    = '0;
    w_fin_r2    = '0;
    w_fin_flags = '0;
    if (!w_is_div) begin
      w_fin_r1    = w_prod_fix[WIDTH-1:0];
      w_fin_r2    = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fin_flags = {w_fin_r2[MSB], w_prod_fix == '0, 2'b00};
    end else if (r_b == '0) begin
      w_fin_r1    = '1;
      w_fin_r2    = r_a;
      w_fin_flags = {1'b1, 1'b0, 1'b0, 1'b1};
    end else begin
      w_fin_r1    = w_quot_fix;
      w_fin_r2    = w_rem_fix;
      w_fin_flags = {w_quot_fix[MSB], w_quot_fix == '0, 1'b0,
                     w_is_signed && (r_a == MOST_NEG) && (r_b == '1)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_flags   <= '0;
    end else if (w_accept) begin
      r_op  <= w_in_op;
      r_a   <= a;
      r_b   <= b;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= magnitude(a, is_signed_op(w_in_op));
      if (!is_iter(w_in_op)) begin
        r_result1 <= w_alu_r1;
        r_result2 <= '0;
        r_flags   <= {w_alu_r1[MSB], w_alu_r1 == '0, w_alu_c, w_alu_v};
      end
    end else if (r_state == S_EXEC) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result1 <= w_fin_r1;
        r_result2 <= w_fin_r2;
        r_flags   <= w_fin_flags;
      end
    end
  end

  assign busy     = (r_state == S_EXEC);
  assign done     = (r_state == S_DONE);
  assign Result1  = r_result1;
  assign Result2  = r_result2;
  assign ALUFlags = r_flags;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=32): expected results are queued at issue
// and compared, with their due cycle, whenever done is seen.
module tb_alu_iter;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] UMULL = 3'b100, SMULL = 3'b101, UDIV = 3'b110, SDIV = 3'b111;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  fl;
    int          due;
    logic [2:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  ALUControl;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] Result1, Result2;
  logic [3:0]  ALUFlags;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .a(a), .b(b), .busy(busy), .done(done),
    .Result1(Result1), .Result2(Result2), .ALUFlags(ALUFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] fl);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.fl = fl; e.due = 0; e.op = 3'b000;
    return e;
  endfunction

  // Reference model built on wide native arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, ls;
    logic [63:0] up;
    logic n, z, c, v;
    e = mk(32'h0, 32'h0, 4'h0);
    c = 1'b0; v = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      ADD: begin
        ls = sx + sy; up = {32'h0, x} + {32'h0, y};
        e.r1 = up[31:0]; c = up[32];
        v = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      SUB: begin
        ls = sx - sy; e.r1 = x - y; c = (x >= y);
        v = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      AND_: e.r1 = x & y;
      OR_:  e.r1 = x | y;
      UMULL: begin up = {32'h0, x} * {32'h0, y}; e.r2 = up[63:32]; e.r1 = up[31:0]; end
      SMULL: begin ls = sx * sy; up = ls; e.r2 = up[63:32]; e.r1 = up[31:0]; end
      UDIV: begin
        if (y == 0) begin e.r1 = '1; e.r2 = x; v = 1'b1; end
        else begin e.r1 = x / y; e.r2 = x % y; end
      end
      default: begin
        if (y == 0) begin e.r1 = '1; e.r2 = x; v = 1'b1; end
        else begin
          ls = sx / sy; up = ls; e.r1 = up[31:0];
          ls = sx % sy; up = ls; e.r2 = up[31:0];
          v = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        end
      end
    endcase
    if (op == UMULL || op == SMULL) begin n = e.r2[31]; z = (e.r1 == 0) && (e.r2 == 0); end
    else begin n = e.r1[31]; z = (e.r1 == 0); end
    e.fl = {n, z, c, v};
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accepting edge with inputs scrambled.
  task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input exp_t e, input bit track);
    ALUControl = op; a = x; b = y; start = 1'b1;
    e.due = cyc + 1 + (op[2] ? 32 : 0);
    e.op  = op;
    if (track) sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; ALUControl = 3'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    drive(op, x, y, model(op, x, y), 1'b1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", tag, budget);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        checks += 4;
        if (Result1 !== e.r1) begin errors++; $display("FAIL op%0d Result1 got %h want %h", e.op, Result1, e.r1); end
        if (Result2 !== e.r2) begin errors++; $display("FAIL op%0d Result2 got %h want %h", e.op, Result2, e.r2); end
        if (ALUFlags !== e.fl) begin errors++; $display("FAIL op%0d ALUFlags got %b want %b", e.op, ALUFlags, e.fl); end
        if (cyc != e.due) begin errors++; $display("FAIL op%0d latency done at cycle %0d want %0d", e.op, cyc, e.due); end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL %s done got %b want 0", tag, done); end
    if (Result1 !== 32'h0) begin errors++; $display("FAIL %s Result1 got %h want 0", tag, Result1); end
    if (Result2 !== 32'h0) begin errors++; $display("FAIL %s Result2 got %h want 0", tag, Result2); end
    if (ALUFlags !== 4'h0) begin errors++; $display("FAIL %s ALUFlags got %b want 0", tag, ALUFlags); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUControl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_state");
    reset = 1'b0;
    drive(ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0, 32'h0, 4'b0110), 1'b1);
    wait_done(4, "first_add");
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", busy); end
  endtask

  task automatic test_single_cycle();
    logic [31:0] xs [6] = '{32'h7FFF_FFFF, 32'h0, 32'h5, 32'h8000_0000, 32'hF0F0_1234, 32'h1};
    logic [31:0] ys [6] = '{32'h1, 32'h0, 32'h7, 32'h1, 32'h0FF0_8765, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      for (int op = 0; op < 4; op++) begin
        @(negedge clk);
        issue(3'(op), xs[i], ys[i]);
        wait_done(4, "single");
      end
    end
  endtask

  task automatic test_mul();
    int nbusy;
    @(negedge clk);
    drive(UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 4'b1000), 1'b1);
    nbusy = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    checks++;
    if (nbusy != 32) begin errors++; $display("FAIL umull_busy_cycles got %0d want 32", nbusy); end
    @(negedge clk);
    drive(SMULL, 32'hFFFF_FFFE, 32'h0000_0003, mk(32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000), 1'b1);
    wait_done(40, "smull");
    @(negedge clk); issue(SMULL, 32'h8000_0000, 32'h8000_0000); wait_done(40, "smull_min");
    @(negedge clk); issue(UMULL, 32'h0, 32'h1234_5678);         wait_done(40, "umull_zero");
    @(negedge clk); issue(SMULL, 32'h7FFF_FFFF, 32'hFFFF_FFFF); wait_done(40, "smull_neg");
  endtask

  task automatic test_div();
    @(negedge clk);
    drive(SDIV, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000), 1'b1);
    wait_done(40, "sdiv");
    @(negedge clk);
    drive(UDIV, 32'h1234_5678, 32'h0, mk(32'hFFFF_FFFF, 32'h1234_5678, 4'b1001), 1'b1);
    wait_done(40, "udiv_zero");
    @(negedge clk);
    drive(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'h0, 4'b1001), 1'b1);
    wait_done(40, "sdiv_ovf");
    @(negedge clk); issue(SDIV, 32'h0000_0007, 32'hFFFF_FFFE); wait_done(40, "sdiv_pos_neg");
    @(negedge clk); issue(SDIV, 32'hFFFF_FF00, 32'h0);         wait_done(40, "sdiv_zero");
    @(negedge clk); issue(UDIV, 32'hFFFF_FFFF, 32'h0000_0010); wait_done(40, "udiv_big");
    @(negedge clk); issue(UDIV, 32'h3, 32'h7);                 wait_done(40, "udiv_small");
  endtask

  task automatic test_reset_abort();
    int ndone;
    @(negedge clk); issue(OR_, 32'h0F0F_0000, 32'hF000_00AA); wait_done(4, "pre_abort");
    @(negedge clk);
    drive(UMULL, 32'hDEAD_BEEF, 32'h1234_5678, mk(32'h0, 32'h0, 4'h0), 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("abort");
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    issue(UDIV, 32'd1000, 32'd7);
    repeat (5) begin
      @(negedge clk);
      start = 1'b1; ALUControl = ADD; a = $urandom; b = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(40, "udiv_ignored");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(UDIV, 32'h8765_4321, 32'h0000_1234);
    wait_done(40, "b2b_udiv");
    issue(ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(2, "b2b_add");
    issue(SMULL, 32'hFFFF_8000, 32'h0000_7FFF);
    wait_done(40, "b2b_smull");
    issue(SUB, 32'h1, 32'h2);
    wait_done(2, "b2b_sub");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(op, x, y);
      wait_done(40, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_random();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d results outstanding want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
